// File: rtl/instr_encoder_pkg.sv
// Shared encoding definitions: mnemonics, opcode constants and field bit positions.
// Combinational content only.
// Shared by the instruction encoder and the ALU-control decoder.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      MN_ADD  = 4'd0,  MN_SUB  = 4'd1,  MN_AND  = 4'd2,  MN_ORR  = 4'd3,
      MN_EOR  = 4'd4,  MN_ADDI = 4'd5,  MN_SUBI = 4'd6,  MN_ANDI = 4'd7,
      MN_ORRI = 4'd8,  MN_EORI = 4'd9,  MN_LDUR = 4'd10, MN_STUR = 4'd11,
      MN_CBZ  = 4'd12, MN_CBNZ = 4'd13, MN_MOVK = 4'd14, MN_HALT = 4'd15
   } mnem_e;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   // R-type opcodes [31:21]
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11101010000;
   // I-type opcodes [31:22]
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [9:0]  OP_ANDI = 10'b1001001000;
   localparam logic [9:0]  OP_ORRI = 10'b1011001000;
   localparam logic [9:0]  OP_EORI = 10'b1101001000;
   // D-type opcodes [31:21]
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   // CB-type opcodes [31:24]
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   // MOVK opcode [31:23]
   localparam logic [8:0]  OP_MOVK = 9'b111100101;

   // Field LSB positions within the 32-bit word
   localparam int RD_LSB      = 0;
   localparam int RN_LSB      = 5;
   localparam int RM_LSB      = 16;
   localparam int R_OPC_LSB   = 21;
   localparam int I_IMM_LSB   = 10;
   localparam int I_OPC_LSB   = 22;
   localparam int D_IMM_LSB   = 12;
   localparam int D_OPC_LSB   = 21;
   localparam int CB_IMM_LSB  = 5;
   localparam int CB_OPC_LSB  = 24;
   localparam int MV_IMM_LSB  = 5;
   localparam int MV_HW_LSB   = 21;
   localparam int MV_OPC_LSB  = 23;

   function automatic logic [10:0] r_opc(input mnem_e m);
      case (m)
         MN_SUB:  return OP_SUB;
         MN_AND:  return OP_AND;
         MN_ORR:  return OP_ORR;
         MN_EOR:  return OP_EOR;
         default: return OP_ADD;
      endcase
   endfunction

   function automatic logic [9:0] i_opc(input mnem_e m);
      case (m)
         MN_SUBI: return OP_SUBI;
         MN_ANDI: return OP_ANDI;
         MN_ORRI: return OP_ORRI;
         MN_EORI: return OP_EORI;
         default: return OP_ADDI;
      endcase
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Packs one field bundle into a 32-bit instruction word and range-checks the immediate.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own handshake.
module instr_field_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  mnem_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rn_i,
   input  logic [4:0]  rm_i,
   input  logic [15:0] imm_i,
   input  logic [1:0]  hw_i,
   output logic [31:0] instr_o,
   output logic        legal_o,
   output logic        halt_o
);

   mnem_e op;
   assign op = mnem_e'(mnem_i);

   // Select the format from the mnemonic, place fields, and flag immediates that do not fit.
   always_comb begin
      instr_o = '0;
      legal_o = 1'b1;
      halt_o  = 1'b0;
      case (op)
         MN_ADD, MN_SUB, MN_AND, MN_ORR, MN_EOR: begin
            instr_o[R_OPC_LSB +: 11] = r_opc(op);
            instr_o[RM_LSB +: 5]     = rm_i;
            instr_o[RN_LSB +: 5]     = rn_i;
            instr_o[RD_LSB +: 5]     = rd_i;
         end
         MN_ADDI, MN_SUBI, MN_ANDI, MN_ORRI, MN_EORI: begin
            instr_o[I_OPC_LSB +: 10] = i_opc(op);
            instr_o[I_IMM_LSB +: 12] = imm_i[11:0];
            instr_o[RN_LSB +: 5]     = rn_i;
            instr_o[RD_LSB +: 5]     = rd_i;
            legal_o                  = (imm_i[15:12] == 4'd0);
         end
         MN_LDUR, MN_STUR: begin
            instr_o[D_OPC_LSB +: 11] = (op == MN_LDUR) ? OP_LDUR : OP_STUR;
            instr_o[D_IMM_LSB +: 9]  = imm_i[8:0];
            instr_o[RN_LSB +: 5]     = rn_i;
            instr_o[RD_LSB +: 5]     = rd_i;
            // signed 9-bit offset: every bit above bit 8 must copy the sign
            legal_o                  = (imm_i[15:8] == 8'h00) || (imm_i[15:8] == 8'hFF);
         end
         MN_CBZ, MN_CBNZ: begin
            instr_o[CB_OPC_LSB +: 8]  = (op == MN_CBZ) ? OP_CBZ : OP_CBNZ;
            instr_o[CB_IMM_LSB +: 19] = {{3{imm_i[15]}}, imm_i};
            instr_o[RD_LSB +: 5]      = rd_i;
         end
         MN_MOVK: begin
            instr_o[MV_OPC_LSB +: 9]  = OP_MOVK;
            instr_o[MV_HW_LSB +: 2]   = hw_i;
            instr_o[MV_IMM_LSB +: 16] = imm_i;
            instr_o[RD_LSB +: 5]      = rd_i;
         end
         MN_HALT: halt_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts field bundles, emits encoded words with target addresses.
// One cycle from accepted bundle to out_valid.
// in_ready drops while an emitted word is stalled by out_ready; words hold stable until taken.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mnem,
   input  logic [4:0]        rd,
   input  logic [4:0]        rn,
   input  logic [4:0]        rm,
   input  logic [15:0]       imm,
   input  logic [1:0]        hw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_cnt
);

   localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

   state_e            state_q, state_d;
   logic              out_valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic [7:0]        err_cnt_q;

   logic [31:0]       word;
   logic              legal, halt;
   logic              in_fire, out_fire, session_start;

   instr_field_pack u_pack (
      .mnem_i  (mnem),
      .rd_i    (rd),
      .rn_i    (rn),
      .rm_i    (rm),
      .imm_i   (imm),
      .hw_i    (hw),
      .instr_o (word),
      .legal_o (legal),
      .halt_o  (halt)
   );

   assign out_fire      = out_valid_q && out_ready;
   assign in_fire       = in_valid && in_ready;
   assign session_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Session FSM: next state plus the state-derived handshake and status outputs.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            busy     = 1'b1;
            in_ready = !out_valid_q || out_ready;
            if (in_valid && in_ready && halt) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!out_valid_q || out_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Output word register and address counter; addr always names the pending or next word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         addr_q      <= BASE;
      end else begin
         if (session_start) addr_q <= BASE;
         else if (out_fire) addr_q <= addr_q + ADDR_W'(1);
         if (in_fire && !halt && legal) begin
            out_valid_q <= 1'b1;
            instr_q     <= word;
         end else if (out_fire) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Sticky error flag and saturating count of rejected bundles, cleared per session.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (session_start) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (in_fire && !halt && !legal) begin
         err_q <= 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign out_valid = out_valid_q;
   assign instr     = instr_q;
   assign addr      = addr_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10: width of the instruction-memory word address.
REQ-002 Parameter BASE_ADDR, default 0: first word address written after start.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle pulse; begins a program-load session.
REQ-006 Port in_valid  input  1 / in_ready  output  1: field-bundle handshake; transfer when both are high.
REQ-007 Port mnem  input  4: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 ADDI, 6 SUBI, 7 ANDI, 8 ORRI, 9 EORI, 10 LDUR, 11 STUR, 12 CBZ, 13 CBNZ, 14 MOVK, 15 HALT.
REQ-008 Ports rd, rn, rm  input  5 each; imm  input  16 (signed for LDUR/STUR/CBZ/CBNZ, unsigned otherwise); hw  input  2 (MOVK shift).
REQ-009 Port out_valid  output  1 / out_ready  input  1: encoded-word handshake; transfer when both are high.
REQ-010 Port instr  output  32: encoded instruction. Port addr  output  ADDR_W: target word address.
REQ-011 Port busy  output  1; done  output  1; err  output  1 (sticky); err_cnt  output  8.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: in_ready=0; start moves to RUN, loads the address counter with BASE_ADDR, and clears err, err_cnt and done.
REQ-014 RUN: in_ready = !out_valid || out_ready; each accepted legal bundle registers instr and addr and sets out_valid on the next cycle, giving a latency of one cycle.
REQ-015 The R-type encoding SHALL be opcode[31:21] (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11101010000), Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
REQ-016 The I-type encoding SHALL be opcode[31:22] (ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000), imm[11:0] at [21:10], Rn, Rd.
REQ-017 The D-type encoding SHALL be opcode[31:21] (LDUR 11111000010, STUR 11111000000), imm[8:0] at [20:12], [11:10]=00, Rn, Rt=rd.
REQ-018 The CB-type encoding SHALL be opcode[31:24] (CBZ 10110100, CBNZ 10110101), imm sign-extended to 19 bits at [23:5], Rt=rd at [4:0].
REQ-019 The MOVK encoding SHALL be 111100101 at [31:23], hw at [22:21], imm at [20:5], Rd.
REQ-020 Range check: I-type requires imm[15:12]==0; D-type requires imm[15:8] all equal to imm[8].
REQ-021 A failing bundle SHALL be accepted but not emitted: err=1, err_cnt increments (saturating at 255), and the address counter is unchanged.
REQ-022 addr SHALL increment by 1 on each output transfer and wrap from 2^ADDR_W-1 to 0 without error.
REQ-023 An accepted HALT SHALL cause a move to DRAIN; DRAIN waits for the pending output transfer, then moves to DONE.
REQ-024 DONE: done=1 and in_ready=0; start returns to RUN (REQ-013 actions).
REQ-025 start while in RUN or DRAIN SHALL be ignored.
REQ-026 instr and addr SHALL hold stable while out_valid && !out_ready.
REQ-027 busy=1 SHALL hold in RUN and DRAIN.

Reset
REQ-028 Reset SHALL set: state IDLE, out_valid 0, instr 0, addr BASE_ADDR, err 0, err_cnt 0, done 0, busy 0.
REQ-029 Reset mid-session SHALL abort the session; a pending word is discarded and not emitted.

Structure
REQ-030 A shared package SHALL hold the mnemonic enum, the opcode constants and the field bit positions, shared with the ALU-control decoder.
REQ-031 One combinational sub-module, instr_field_pack, SHALL perform encoding and range checking; the FSM, output register and counters stay in the top.

Verification
REQ-032 start; ADD rd=1 rn=2 rm=3, out_ready=1 -> next cycle instr=0x8B030041, addr=0.
REQ-033 ADDI rd=4 rn=5 imm=0x1000 -> no out_valid, err=1, err_cnt=1, next legal word still at addr 0.
REQ-034 CBZ rd=9 imm=0xFFFF -> instr=0xB4FFFFE9.
REQ-035 out_ready=0 for 3 cycles with a word pending -> in_ready=0, instr/addr stable; release -> single transfer.
REQ-036 ADDR_W=2: five legal words -> addr sequence 0,1,2,3,0; HALT -> DRAIN then DONE, done=1.
REQ-037 Assert reset while out_valid=1 -> out_valid=0 immediately, state IDLE, addr=BASE_ADDR.
